chip8_alu_seq: RTL and testbench
================================

# chip8_alu_seq

Multi-cycle sequencer that executes CHIP-8 8XYN arithmetic/logic instructions: it reads VX and VY from the register file, drives the combinational ALU, then writes the result to VX and the flag to VF. It sits between the instruction decoder (start/done handshake) and the shared single-read/single-write V-register file, owning both ports for the duration of an operation.

## Interface
- `VF_IDX`, 15: register index written with the ALU flag.
- `clk` input 1: system clock, all state on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: decoder request; sampled only in IDLE.
- `x` input 4: VX index (N of 8XYN is `op`).
- `y` input 4: VY index.
- `op` input 4: ALU opcode (low nibble of 8XYN).
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle completion pulse.
- `illegal` output 1: pulses with `done` when `op` was not 0–7 or 0xE.
- `rf_raddr` output 4: register-file read address; data returns next cycle.
- `rf_rdata` input 8: register-file read data.
- `rf_we` output 1: register-file write enable.
- `rf_waddr` output 4: write address.
- `rf_wdata` output 8: write data.
- `alu_a`, `alu_b` output 8: ALU operands (registered VX, VY).
- `alu_op` output 4: registered opcode.
- `alu_out` input 8: ALU result.
- `alu_vf_wr` input 1: ALU requests VF update.
- `alu_flag` input 1: ALU carry/borrow/shifted-out bit.

## Operation
- States: IDLE → RD_X → RD_Y → EXEC → WB_X → WB_F → IDLE. The sequence is fixed; no state is skipped.
- IDLE: when `start`=1, latch `x`, `y`, `op` and go to RD_X. If `op` is not in {0..7, 0xE}, set an internal illegal bit.
- RD_X: `rf_raddr`=x.
- RD_Y: capture `rf_rdata` into the A register; `rf_raddr`=y.
- EXEC: capture `rf_rdata` into the B register. Combinationally, `alu_a`/`alu_b`/`alu_op` feed the ALU. At end of cycle, latch `alu_out`, `alu_vf_wr` and `alu_flag`.
- WB_X: `rf_we`=1 unless illegal, `rf_waddr`=x, `rf_wdata`=latched result.
- WB_F: `rf_we`=latched vf_wr and not illegal, `rf_waddr`=VF_IDX, `rf_wdata`={7'b0, latched flag}. `done`=1; `illegal`=internal illegal bit.
- VF is always written after VX, so for X=F the flag value is the final VF contents.
- `start` while busy is ignored. There is no queue, and the decoder must wait for `done`.
- `alu_a`, `alu_b` and `alu_op` hold their last values outside EXEC.
- `rf_raddr` is don't-care outside RD_X/RD_Y; it is driven 0 in IDLE.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `illegal`=0, `rf_we`=0, `rf_raddr`=0, `rf_waddr`=0, `rf_wdata`=0, `alu_a`=0, `alu_b`=0, `alu_op`=0.
- Latency: if `start` is sampled on edge 0, `done` is high during cycle 5 (the WB_F state). `busy` is high in cycles 1–5. A new `start` is accepted in cycle 6 at the earliest.
- Writes occur in cycle 4 (VX) and cycle 5 (VF). Throughput is one instruction per 6 cycles.
- Register-file read latency is exactly one cycle.
- Reset asserted mid-operation: the block returns to IDLE immediately and asynchronously, `rf_we` drops at once, and no further writes occur. The operation is lost and `done` is not pulsed.
- Control outputs `rf_we`, `done`, `illegal` and `busy` are decoded from registered state only, so they are glitch-free.

## Configuration
- `CHIP8_VF_RESET_EN` defined: for `op` 1, 2 or 3 (OR/AND/XOR), WB_F writes VF=0x00 (`rf_we`=1), matching the COSMAC VIP quirk.
- `CHIP8_VF_RESET_EN` undefined: VF is written only when the ALU asserts `alu_vf_wr`, so OR/AND/XOR leave VF unchanged.

## Test plan
- ADD: V1=0xF0, V2=0x20, start x=1 y=2 op=4 → V1=0x10 (cycle 4), VF=0x01 (cycle 5), `done` in cycle 5, `illegal`=0.
- SUB with X=F: VF=0x05, VE=0x03, x=F y=E op=5 → cycle-4 write VF=0x02, cycle-5 write VF=0x01; final VF=0x01.
- OR: V3=0x0F, V4=0xF0, VF=0x07, x=3 y=4 op=1 → V3=0xFF. With the macro, VF=0x00; without it, VF stays 0x07 and there is no write in cycle 5.
- Illegal op=8 → no `rf_we` in any cycle; `done`=`illegal`=1 in cycle 5; register file unchanged.
- Back-to-back: second `start` held high through cycles 1–5 is ignored until IDLE, then accepted in cycle 6; its `done` appears in cycle 11.
- Reset: deassert `rst_n` during EXEC (cycle 3) → `busy`=0 and `rf_we`=0 immediately, no write to VX/VF, no `done`; the next `start` after reset release completes normally.

Source files
------------

// File: rtl/chip8_alu_seq.sv
// CHIP-8 8XYN sequencer: read VX/VY, run the external ALU, write VX then VF.
// Build option: CHIP8_VF_RESET_EN clears VF after OR/AND/XOR.
module chip8_alu_seq #(
  parameter logic [3:0] VF_IDX = 4'hF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic [3:0] op,
  output logic       busy,
  output logic       done,
  output logic       illegal,
  output logic [3:0] rf_raddr,
  input  logic [7:0] rf_rdata,
  output logic       rf_we,
  output logic [3:0] rf_waddr,
  output logic [7:0] rf_wdata,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_op,
  input  logic [7:0] alu_out,
  input  logic       alu_vf_wr,
  input  logic       alu_flag
);

  typedef enum logic [2:0] {
    IDLE, RD_X, RD_Y, EXEC, WB_X, WB_F
  } state_t;

  state_t     state_q;
  logic [3:0] x_q, y_q, op_q, aop_q;
  logic [7:0] a_q, b_q, res_q;
  logic       ill_q, vfwr_q, flag_q;
  logic       op_ok;
  logic       vf_clr;

  assign op_ok = !op[3] || (op == 4'hE);

`ifdef CHIP8_VF_RESET_EN
  assign vf_clr = (op_q == 4'h1) || (op_q == 4'h2) ||
                  (op_q == 4'h3);
`else
  assign vf_clr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      op_q    <= '0;
      aop_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ill_q   <= 1'b0;
      vfwr_q  <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            x_q     <= x;
            y_q     <= y;
            op_q    <= op;
            ill_q   <= !op_ok;
            state_q <= RD_X;
          end
        end
        RD_X: state_q <= RD_Y;
        RD_Y: begin
          a_q     <= rf_rdata;
          state_q <= EXEC;
        end
        EXEC: begin
          b_q     <= rf_rdata;
          aop_q   <= op_q;
          res_q   <= alu_out;
          vfwr_q  <= alu_vf_wr;
          flag_q  <= alu_flag;
          state_q <= WB_X;
        end
        WB_X: state_q <= WB_F;
        WB_F: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == WB_F);
  assign illegal = done && ill_q;

  // VY arrives straight from the file in EXEC; hold it afterwards
  assign alu_a  = a_q;
  assign alu_b  = (state_q == EXEC) ? rf_rdata : b_q;
  assign alu_op = (state_q == EXEC) ? op_q : aop_q;

  always_comb begin
    rf_raddr = 4'h0;
    rf_we    = 1'b0;
    rf_waddr = 4'h0;
    rf_wdata = 8'h00;
    unique case (1'b1)
      (state_q == RD_X): rf_raddr = x_q;
      (state_q == RD_Y): rf_raddr = y_q;
      (state_q == WB_X): begin
        rf_we    = !ill_q;
        rf_waddr = x_q;
        rf_wdata = res_q;
      end
      (state_q == WB_F): begin
        rf_waddr = VF_IDX;
        if (vf_clr) begin
          rf_we    = !ill_q;
          rf_wdata = 8'h00;
        end else begin
          rf_we    = vfwr_q && !ill_q;
          rf_wdata = {7'b0, flag_q};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_chip8_alu_seq.sv
// Directed bench for chip8_alu_seq with a register-file and ALU model.
// Honors CHIP8_VF_RESET_EN when choosing expected VF behaviour.
module tb_chip8_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] x, y, op;
  logic       busy, done, illegal;
  logic [3:0] rf_raddr;
  logic [7:0] rf_rdata;
  logic       rf_we;
  logic [3:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_op;
  logic [7:0] alu_out;
  logic       alu_vf_wr, alu_flag;

  logic [7:0] rf [16];
  int total = 0;
  int bad   = 0;
  int done_cnt;

  always #5 clk = ~clk;

  chip8_alu_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x(x), .y(y), .op(op),
    .busy(busy), .done(done), .illegal(illegal),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_vf_wr(alu_vf_wr), .alu_flag(alu_flag)
  );

  always @(posedge clk) begin
    rf_rdata <= rf[rf_raddr];
    if (rf_we) rf[rf_waddr] <= rf_wdata;
  end

  always_comb begin
    alu_out   = 8'h00;
    alu_vf_wr = 1'b0;
    alu_flag  = 1'b0;
    case (alu_op)
      4'h0: alu_out = alu_b;
      4'h1: alu_out = alu_a | alu_b;
      4'h2: alu_out = alu_a & alu_b;
      4'h3: alu_out = alu_a ^ alu_b;
      4'h4: begin
        {alu_flag, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
        alu_vf_wr = 1'b1;
      end
      4'h5: begin
        alu_out = alu_a - alu_b;
        alu_flag = (alu_a >= alu_b);
        alu_vf_wr = 1'b1;
      end
      4'h6: begin
        alu_out = alu_a >> 1;
        alu_flag = alu_a[0];
        alu_vf_wr = 1'b1;
      end
      4'h7: begin
        alu_out = alu_b - alu_a;
        alu_flag = (alu_b >= alu_a);
        alu_vf_wr = 1'b1;
      end
      4'hE: begin
        alu_out = alu_a << 1;
        alu_flag = alu_a[7];
        alu_vf_wr = 1'b1;
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [3:0] tx, input logic [3:0] ty,
                       input logic [3:0] top,
                       input logic [7:0] ea, input logic [7:0] eb,
                       input logic [7:0] eres,
                       input logic ewe5, input logic [7:0] ed5,
                       input logic eill);
    @(negedge clk);
    start = 1'b1; x = tx; y = ty; op = top;
    tick();
    start = 1'b0;
    chk("c1_busy", 8'(busy), 8'h1);
    chk("c1_raddr", 8'(rf_raddr), 8'(tx));
    chk("c1_we", 8'(rf_we), 8'h0);
    tick();
    chk("c2_raddr", 8'(rf_raddr), 8'(ty));
    tick();
    chk("c3_alu_a", alu_a, ea);
    chk("c3_alu_b", alu_b, eb);
    chk("c3_alu_op", 8'(alu_op), 8'(top));
    chk("c3_done", 8'(done), 8'h0);
    tick();
    chk("c4_we", 8'(rf_we), 8'(!eill));
    chk("c4_alu_b_hold", alu_b, eb);
    if (!eill) begin
      chk("c4_waddr", 8'(rf_waddr), 8'(tx));
      chk("c4_wdata", rf_wdata, eres);
    end
    tick();
    chk("c5_we", 8'(rf_we), 8'(ewe5));
    chk("c5_done", 8'(done), 8'h1);
    chk("c5_illegal", 8'(illegal), 8'(eill));
    if (ewe5) begin
      chk("c5_waddr", 8'(rf_waddr), 8'hF);
      chk("c5_wdata", rf_wdata, ed5);
    end
    tick();
    chk("c6_busy", 8'(busy), 8'h0);
    chk("c6_done", 8'(done), 8'h0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 8'h00;
    start = 1'b0; x = 4'h0; y = 4'h0; op = 4'h0;
    rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_busy", 8'(busy), 8'h0);
    chk("rst_done", 8'(done), 8'h0);
    chk("rst_illegal", 8'(illegal), 8'h0);
    chk("rst_we", 8'(rf_we), 8'h0);
    chk("rst_raddr", 8'(rf_raddr), 8'h0);
    chk("rst_waddr", 8'(rf_waddr), 8'h0);
    chk("rst_wdata", rf_wdata, 8'h00);
    chk("rst_alu_a", alu_a, 8'h00);
    chk("rst_alu_b", alu_b, 8'h00);
    chk("rst_alu_op", 8'(alu_op), 8'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD with carry
    rf[1] = 8'hF0; rf[2] = 8'h20;
    do_op(4'h1, 4'h2, 4'h4, 8'hF0, 8'h20, 8'h10, 1'b1, 8'h01, 1'b0);
    chk("add_v1", rf[1], 8'h10);
    chk("add_vf", rf[15], 8'h01);

    // SUB into VF: flag wins
    rf[15] = 8'h05; rf[14] = 8'h03;
    do_op(4'hF, 4'hE, 4'h5, 8'h05, 8'h03, 8'h02, 1'b1, 8'h01, 1'b0);
    chk("sub_vf", rf[15], 8'h01);

    // OR: VF behaviour depends on build option
    rf[3] = 8'h0F; rf[4] = 8'hF0; rf[15] = 8'h07;
`ifdef CHIP8_VF_RESET_EN
    do_op(4'h3, 4'h4, 4'h1, 8'h0F, 8'hF0, 8'hFF, 1'b1, 8'h00, 1'b0);
    chk("or_vf", rf[15], 8'h00);
`else
    do_op(4'h3, 4'h4, 4'h1, 8'h0F, 8'hF0, 8'hFF, 1'b0, 8'h00, 1'b0);
    chk("or_vf", rf[15], 8'h07);
`endif
    chk("or_v3", rf[3], 8'hFF);

    // illegal opcode
    rf[15] = 8'h07;
    do_op(4'h1, 4'h2, 4'h8, 8'h10, 8'h20, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("ill_v1", rf[1], 8'h10);
    chk("ill_vf", rf[15], 8'h07);

    // shift left
    rf[7] = 8'h81;
    do_op(4'h7, 4'h0, 4'hE, 8'h81, 8'h00, 8'h02, 1'b1, 8'h01, 1'b0);
    chk("shl_v7", rf[7], 8'h02);

    // back-to-back: start held high
    rf[5] = 8'h03; rf[6] = 8'h04;
    @(negedge clk);
    start = 1'b1; x = 4'h5; y = 4'h6; op = 4'h7;
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (c == 7) start = 1'b0;
      chk($sformatf("b2b_busy_c%0d", c), 8'(busy),
          8'((c != 6)));
      chk($sformatf("b2b_done_c%0d", c), 8'(done),
          8'((c == 5) || (c == 11)));
    end
    tick();
    chk("b2b_idle", 8'(busy), 8'h0);
    chk("b2b_v5", rf[5], 8'h03);
    chk("b2b_vf", rf[15], 8'h01);

    // reset during EXEC
    rf[8] = 8'h11; rf[9] = 8'h22;
    @(negedge clk);
    start = 1'b1; x = 4'h8; y = 4'h9; op = 4'h4;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_rst_alu_a", alu_a, 8'h11);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 8'(busy), 8'h0);
    chk("arst_we", 8'(rf_we), 8'h0);
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (done) done_cnt++;
      if (rf_we) done_cnt++;
    end
    chk("arst_no_done_we", 8'(done_cnt), 8'h0);
    chk("arst_v8", rf[8], 8'h11);
    chk("arst_vf", rf[15], 8'h01);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(4'h8, 4'h9, 4'h4, 8'h11, 8'h22, 8'h33, 1'b1, 8'h00, 1'b0);
    chk("post_rst_v8", rf[8], 8'h33);
    chk("post_rst_vf", rf[15], 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
